mips32_4stage: RTL and testbench

MIPS32_4STAGE -- requirements
Module: mips32_4stage

---
 rtl/mips32_4stage.sv | 96 +++++++++
 tb/tb_mips32_4stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mips32_4stage.sv
// mips32_4stage: four-stage (IF, ID, EX, MEM/WB) MIPS32 subset pipeline with
// full forwarding, combinational load data, EX-stage branch resolution and no stalls.
module mips32_4stage (
  input logic clk1,
  input logic rst_n
);
  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;
  logic [31:0] pc, IF_ID_IR, IF_ID_NPC;
  logic [31:0] ID_EX_IR, ID_EX_NPC, ID_EX_A, ID_EX_B, ID_EX_Imm;
  logic [31:0] EX_MEM_IR, EX_MEM_ALUOut, EX_MEM_B;
  logic        EX_MEM_Cond, HALTED, TAKEN_BRANCH;
  logic [31:0] Reg [0:31];
  logic [31:0] Mem [0:1023];
  logic [5:0]  w_ex_op, w_wb_op;
  logic [4:0]  w_id_rs, w_id_rt, w_ex_rs, w_ex_rt, w_wb_dst;
  logic        w_wb_we, w_taken, w_unused;
  logic [31:0] w_wb_data, w_id_a, w_id_b, w_ex_a, w_ex_b, w_alu;
  assign w_wb_op   = EX_MEM_IR[31:26];
  assign w_wb_dst  = w_wb_op <= OP_MUL ? EX_MEM_IR[15:11] : EX_MEM_IR[20:16];
  assign w_wb_we   = (w_wb_op <= OP_MUL || w_wb_op == OP_LW || w_wb_op == OP_ADDI ||
                      w_wb_op == OP_SUBI || w_wb_op == OP_SLTI) && w_wb_dst != 5'd0;
  assign w_wb_data = w_wb_op == OP_LW ? Mem[EX_MEM_ALUOut[9:0]] : EX_MEM_ALUOut;
  // ID reads see the value being written back in the same cycle
  assign w_id_rs = IF_ID_IR[25:21];
  assign w_id_rt = IF_ID_IR[20:16];
  assign w_id_a  = w_id_rs == 5'd0 ? '0 : (w_wb_we && w_wb_dst == w_id_rs) ? w_wb_data : Reg[w_id_rs];
  assign w_id_b  = w_id_rt == 5'd0 ? '0 : (w_wb_we && w_wb_dst == w_id_rt) ? w_wb_data : Reg[w_id_rt];
  assign w_ex_op = ID_EX_IR[31:26];
  assign w_ex_rs = ID_EX_IR[25:21];
  assign w_ex_rt = ID_EX_IR[20:16];
  assign w_ex_a  = (w_wb_we && w_wb_dst == w_ex_rs) ? w_wb_data : ID_EX_A;
  assign w_ex_b  = (w_wb_we && w_wb_dst == w_ex_rt) ? w_wb_data : ID_EX_B;
  assign w_alu = w_ex_op == OP_ADD  ? w_ex_a + w_ex_b :
                 w_ex_op == OP_SUB  ? w_ex_a - w_ex_b :
                 w_ex_op == OP_AND  ? w_ex_a & w_ex_b :
                 w_ex_op == OP_OR   ? w_ex_a | w_ex_b :
                 w_ex_op == OP_SLT  ? {31'd0, $signed(w_ex_a) < $signed(w_ex_b)} :
                 w_ex_op == OP_MUL  ? w_ex_a * w_ex_b :
                 (w_ex_op == OP_LW || w_ex_op == OP_SW || w_ex_op == OP_ADDI) ? w_ex_a + ID_EX_Imm :
                 w_ex_op == OP_SUBI ? w_ex_a - ID_EX_Imm :
                 w_ex_op == OP_SLTI ? {31'd0, $signed(w_ex_a) < $signed(ID_EX_Imm)} : '0;
  assign w_taken = (w_ex_op == OP_BEQZ && w_ex_a == '0) || (w_ex_op == OP_BNEQZ && w_ex_a != '0);
  // IR fields and the branch flag that no later stage consumes
  assign w_unused = ^{EX_MEM_IR[25:21], EX_MEM_IR[10:0], EX_MEM_Cond};
  always_ff @(posedge clk1 or negedge rst_n)
    if (!rst_n) begin
      pc            <= '0;
      IF_ID_IR      <= '0;
      IF_ID_NPC     <= '0;
      ID_EX_IR      <= '0;
      ID_EX_NPC     <= '0;
      ID_EX_A       <= '0;
      ID_EX_B       <= '0;
      ID_EX_Imm     <= '0;
      EX_MEM_IR     <= '0;
      EX_MEM_ALUOut <= '0;
      EX_MEM_B      <= '0;
      EX_MEM_Cond   <= 1'b0;
      HALTED        <= 1'b0;
      TAKEN_BRANCH  <= 1'b0;
    end else if (w_wb_op == OP_HLT) begin
      HALTED <= 1'b1;
    end else begin
      pc            <= w_taken ? ID_EX_NPC + ID_EX_Imm : pc + 32'd1;
      IF_ID_IR      <= w_taken ? '0 : Mem[pc[9:0]];
      IF_ID_NPC     <= pc + 32'd1;
      TAKEN_BRANCH  <= w_taken;
      ID_EX_IR      <= w_taken ? '0 : IF_ID_IR;
      ID_EX_NPC     <= IF_ID_NPC;
      ID_EX_A       <= w_id_a;
      ID_EX_B       <= w_id_b;
      ID_EX_Imm     <= {{16{IF_ID_IR[15]}}, IF_ID_IR[15:0]};
      EX_MEM_IR     <= ID_EX_IR;
      EX_MEM_ALUOut <= w_alu;
      EX_MEM_B      <= w_ex_b;
      EX_MEM_Cond   <= w_ex_a == '0;
    end
  // Architectural storage is never reset; reset clears EX_MEM_IR to a NOP instead
  always_ff @(posedge clk1) begin
    if (w_wb_we) Reg[w_wb_dst] <= w_wb_data;
    if (w_wb_op == OP_SW) Mem[EX_MEM_ALUOut[9:0]] <= EX_MEM_B;
  end
endmodule

// File: tb/tb_mips32_4stage.sv
// tb_mips32_4stage: directed programs on mips32_4stage checked against hand-computed
// register, memory and pipeline-control values.
module tb_mips32_4stage;
  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, AND = 6'b000010, OR = 6'b000011;
  localparam logic [5:0] SLT = 6'b000100, MUL = 6'b000101, LW = 6'b001000, SW = 6'b001001;
  localparam logic [5:0] ADDI = 6'b001010, SUBI = 6'b001011, SLTI = 6'b001100;
  localparam logic [5:0] BNEQZ = 6'b001101, BEQZ = 6'b001110;
  localparam logic [31:0] HLT_W = 32'hFC00_0000;
  logic clk1 = 1'b0;
  logic rst_n = 1'b1;
  int vecs = 0;
  int errs = 0;
  mips32_4stage dut (.clk1(clk1), .rst_n(rst_n));
  always #5 clk1 = ~clk1;
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end
  function automatic logic [31:0] r_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction
  function automatic logic [31:0] i_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wipe();
    @(negedge clk1);
    rst_n = 1'b0;
    for (int i = 0; i < 1024; i++) dut.Mem[i] = '0;
    for (int i = 0; i < 32; i++) dut.Reg[i] = '0;
  endtask
  task automatic start();
    @(negedge clk1);
    rst_n = 1'b1;
  endtask
  task automatic halt_run(output int pulses);
    pulses = 0;
    for (int c = 0; c < 300 && !dut.HALTED; c++) begin
      @(negedge clk1);
      if (dut.TAKEN_BRANCH) pulses++;
    end
    chk("halted", 32'(dut.HALTED), 32'd1);
  endtask
  task automatic load_basic();
    dut.Reg[1] = 32'd5;
    dut.Reg[2] = 32'd3;
    dut.Mem[0] = r_i(ADD, 1, 2, 3);
    dut.Mem[1] = r_i(SUB, 3, 2, 4);
    dut.Mem[2] = i_i(ADDI, 4, 5, 16'd10);
    dut.Mem[3] = i_i(SW, 0, 5, 16'd100);
    dut.Mem[4] = i_i(LW, 0, 6, 16'd100);
    dut.Mem[5] = i_i(BEQZ, 6, 0, 16'd2);
    dut.Mem[6] = i_i(ADDI, 6, 6, 16'd1);
    dut.Mem[7] = HLT_W;
    dut.Mem[8] = i_i(ADDI, 0, 7, 16'd9);
    dut.Mem[9] = i_i(ADDI, 0, 7, 16'd9);
  endtask
  initial begin
    int n;
    #1 rst_n = 1'b0;
    #1;
    chk("rst pc", dut.pc, 32'd0);
    chk("rst HALTED", 32'(dut.HALTED), 32'd0);
    chk("rst TAKEN", 32'(dut.TAKEN_BRANCH), 32'd0);
    chk("rst IF_ID_IR", dut.IF_ID_IR, 32'd0);
    chk("rst ID_EX_IR", dut.ID_EX_IR, 32'd0);
    chk("rst EX_MEM_IR", dut.EX_MEM_IR, 32'd0);
    @(negedge clk1);
    chk("rst held pc", dut.pc, 32'd0);
    // forwarding, store/load, not-taken branch, freeze after HLT
    wipe();
    load_basic();
    start();
    halt_run(n);
    repeat (5) @(negedge clk1);
    chk("basic R3", dut.Reg[3], 32'd8);
    chk("basic R4", dut.Reg[4], 32'd5);
    chk("basic R5", dut.Reg[5], 32'd15);
    chk("basic Mem100", dut.Mem[100], 32'd15);
    chk("basic R6", dut.Reg[6], 32'd16);
    chk("basic pc", dut.pc, 32'd10);
    chk("basic R7 frozen", dut.Reg[7], 32'd0);
    chk("basic no branch", 32'(n), 32'd0);
    // taken BEQZ flushes the shadow instruction
    wipe();
    dut.Reg[2] = 32'd20;
    dut.Reg[3] = 32'd30;
    dut.Mem[0] = i_i(BEQZ, 1, 0, 16'd1);
    dut.Mem[1] = i_i(ADDI, 2, 2, 16'd1);
    dut.Mem[2] = i_i(ADDI, 3, 3, 16'd1);
    dut.Mem[3] = HLT_W;
    start();
    halt_run(n);
    chk("beqz R2", dut.Reg[2], 32'd20);
    chk("beqz R3", dut.Reg[3], 32'd31);
    chk("beqz pulses", 32'(n), 32'd1);
    chk("beqz pc", dut.pc, 32'd6);
    // BNEQZ loop; the HLT in the shadow is flushed twice
    wipe();
    dut.Reg[1] = 32'd3;
    dut.Mem[0] = i_i(SUBI, 1, 1, 16'd1);
    dut.Mem[1] = i_i(BNEQZ, 1, 0, 16'hFFFE);
    dut.Mem[2] = HLT_W;
    start();
    halt_run(n);
    chk("loop R1", dut.Reg[1], 32'd0);
    chk("loop pulses", 32'(n), 32'd2);
    // ALU ops, R0 protection, undefined opcode, address wrap
    wipe();
    dut.Reg[8]  = 32'hFFFF_FFFF;
    dut.Reg[9]  = 32'd1;
    dut.Reg[10] = 32'h0000_F0F0;
    dut.Reg[11] = 32'h0000_0FF0;
    dut.Reg[12] = 32'd7;
    dut.Reg[13] = 32'd6;
    dut.Reg[15] = 32'd99;
    dut.Reg[20] = 32'd55;
    dut.Reg[22] = 32'h22;
    dut.Reg[25] = 32'd4096;
    dut.Mem[0]  = i_i(ADDI, 0, 0, 16'd7);
    dut.Mem[1]  = r_i(ADD, 0, 9, 21);
    dut.Mem[2]  = r_i(SLT, 8, 9, 14);
    dut.Mem[3]  = r_i(SLT, 9, 8, 15);
    dut.Mem[4]  = r_i(MUL, 12, 13, 16);
    dut.Mem[5]  = r_i(AND, 10, 11, 17);
    dut.Mem[6]  = r_i(OR, 10, 11, 18);
    dut.Mem[7]  = i_i(SUBI, 9, 19, 16'd5);
    dut.Mem[8]  = i_i(SLTI, 8, 20, 16'd0);
    dut.Mem[9]  = i_i(6'b010000, 9, 22, 16'd5);
    dut.Mem[10] = i_i(SW, 25, 9, 16'd900);
    dut.Mem[11] = i_i(LW, 25, 26, 16'd900);
    dut.Mem[12] = r_i(MUL, 8, 8, 27);
    dut.Mem[13] = r_i(ADD, 8, 9, 28);
    dut.Mem[14] = HLT_W;
    start();
    halt_run(n);
    chk("R0 stays 0", dut.Reg[0], 32'd0);
    chk("no fwd of R0", dut.Reg[21], 32'd1);
    chk("SLT -1<1", dut.Reg[14], 32'd1);
    chk("SLT 1<-1", dut.Reg[15], 32'd0);
    chk("MUL 7*6", dut.Reg[16], 32'd42);
    chk("AND", dut.Reg[17], 32'h0000_00F0);
    chk("OR", dut.Reg[18], 32'h0000_FFF0);
    chk("SUBI", dut.Reg[19], 32'hFFFF_FFFC);
    chk("SLTI", dut.Reg[20], 32'd1);
    chk("undef NOP", dut.Reg[22], 32'h22);
    chk("SW wrap", dut.Mem[900], 32'd1);
    chk("LW wrap", dut.Reg[26], 32'd1);
    chk("MUL wrap", dut.Reg[27], 32'd1);
    chk("ADD wrap", dut.Reg[28], 32'd0);
    // reset mid-program and while halted
    wipe();
    load_basic();
    start();
    repeat (4) @(negedge clk1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst pc", dut.pc, 32'd0);
    chk("midrst HALTED", 32'(dut.HALTED), 32'd0);
    chk("midrst EX_MEM_IR", dut.EX_MEM_IR, 32'd0);
    chk("midrst R3 kept", dut.Reg[3], 32'd8);
    chk("midrst R4 aborted", dut.Reg[4], 32'd0);
    chk("midrst R1 kept", dut.Reg[1], 32'd5);
    chk("midrst Mem3 kept", dut.Mem[3], i_i(SW, 0, 5, 16'd100));
    start();
    halt_run(n);
    chk("rerun R4", dut.Reg[4], 32'd5);
    chk("rerun pc", dut.pc, 32'd10);
    #2 rst_n = 1'b0;
    #1;
    chk("haltrst HALTED", 32'(dut.HALTED), 32'd0);
    chk("haltrst pc", dut.pc, 32'd0);
    start();
    @(negedge clk1);
    chk("refetch pc", dut.pc, 32'd1);
    chk("refetch IR", dut.IF_ID_IR, r_i(ADD, 1, 2, 3));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
